// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch queue.
package if_pkg;

  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned INSTR_W_DEF = 32;

  // BOOT loads StartPC on the first edge out of reset; RUN persists until reset
  typedef enum logic {
    StBoot = 1'b0,
    StRun  = 1'b1
  } if_state_e;

  // One prefetched instruction with the pc it was fetched from
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface if_prefetch_queue_if
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) ();

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with flush; pointers wrap modulo DEPTH (power of 2).
module if_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Pipelined instruction fetch with a DEPTH-entry prefetch queue feeding the ID register.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned        ADDR_W  = ADDR_W_DEF,
  parameter int unsigned        INSTR_W = INSTR_W_DEF,
  parameter int unsigned        DEPTH   = 4,
  parameter int unsigned        PC_INC  = 4,
  parameter logic [INSTR_W-1:0] BUBBLE  = '0
) (
  input  logic                clk,
  input  logic                resetl,
  input  logic [ADDR_W-1:0]   StartPC,
  input  logic                PCSrc,
  input  logic [ADDR_W-1:0]   TargetPC,
  input  logic                pc_stall,
  if_prefetch_queue_if.master imem,
  output logic                valid_ID,
  output logic [ADDR_W-1:0]   pc_ID,
  output logic [INSTR_W-1:0]  instruction_ID
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]          fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]           discard_q, discard_d;
  logic [CNT_W-1:0]           outstanding, q_count;
  logic [ADDR_W-1:0]          rsp_pc;
  logic [ADDR_W+INSTR_W-1:0]  q_head;
  logic pc_full, pc_empty, q_full, q_empty;
  logic run, redirect, accept, rsp, keep, q_pop;

  assign run      = (state_q == StRun);
  assign redirect = run && PCSrc;
  assign accept   = imem.req && imem.gnt;
  // Responses with nothing outstanding (e.g. from before a reset) are ignored
  assign rsp      = imem.rvalid && !pc_empty;
  assign keep     = rsp && !redirect && (discard_q == '0);
  assign q_pop    = !redirect && !pc_stall && !q_empty;

  // Queued plus outstanding entries never exceed DEPTH
  always_comb begin
    imem.req  = run && !PCSrc && !pc_full &&
                (({1'b0, q_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH));
    imem.addr = fetch_pc_q;
  end

  // pc of every in-flight request, popped in order as responses return
  if_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_fifo (
    .clk   (clk),
    .resetl(resetl),
    .push  (accept),
    .wdata (fetch_pc_q),
    .pop   (rsp),
    .flush (1'b0),
    .rdata (rsp_pc),
    .full  (pc_full),
    .empty (pc_empty),
    .count (outstanding)
  );

  // Prefetched {pc, instr} pairs waiting for the ID register
  if_sync_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .resetl(resetl),
    .push  (keep),
    .wdata ({rsp_pc, imem.rdata}),
    .pop   (q_pop),
    .flush (redirect),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Next fetch pc and the number of stale responses still to be dropped
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    unique case (state_q)
      StBoot: begin
        state_d    = StRun;
        fetch_pc_d = StartPC;
      end
      StRun: begin
        if (PCSrc) begin
          fetch_pc_d = TargetPC;
          // The response landing on this edge is already counted as dropped
          discard_d  = outstanding - CNT_W'(rsp);
        end else begin
          if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
          if (rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        end
      end
    endcase
  end

  // FSM and fetch state registers
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q    <= StBoot;
      fetch_pc_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  // ID pipeline register: redirect clears it even under stall; an empty queue gives a bubble
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      valid_ID       <= 1'b0;
      pc_ID          <= '0;
      instruction_ID <= BUBBLE;
    end else if (redirect) begin
      valid_ID       <= 1'b0;
      instruction_ID <= BUBBLE;
    end else if (!pc_stall) begin
      if (!q_empty) begin
        valid_ID       <= 1'b1;
        pc_ID          <= q_head[ADDR_W+INSTR_W-1:INSTR_W];
        instruction_ID <= q_head[INSTR_W-1:0];
      end else begin
        valid_ID       <= 1'b0;
        instruction_ID <= BUBBLE;
      end
    end
  end

  // Memory must never return more responses than were requested
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!resetl)
    imem.rvalid |-> !pc_empty)
    else $error("imem response with no request outstanding");

  // The occupancy cap keeps the queue from being pushed while full without a pop
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!resetl)
    !(q_full && keep && !q_pop))
    else $error("prefetch queue overflow");

endmodule
